rocc_accumulator: RTL and testbench

Accelerator-side RoCC responder. It accepts custom instructions forwarded by the execute stage over the RoCC command channel and executes them against a small bank of 64-bit accumulator registers. When the instruction requests a destination register write, it returns a result on the RoCC response channel. It is the counterpart of the core-side RoCC port in the execute stage and sits directly behind it in the accelerator slot.

---
 rtl/rocc_acc_pkg.sv | 32 +++
 rtl/rocc_acc_mac.sv | 50 +++++
 rtl/rocc_accumulator.sv | 147 ++++++++++++++
 tb/tb_rocc_accumulator.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rocc_acc_pkg.sv
// Shared types and constants for the RoCC accumulator accelerator.
package rocc_acc_pkg;

    // Operation codes carried in funct7
    typedef enum logic [6:0] {
        ACC_WRITE = 7'd0,
        ACC_READ  = 7'd1,
        ACC_ACCUM = 7'd2,
        ACC_MAC   = 7'd3
    } acc_op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } acc_state_e;

    // Standard RoCC custom instruction layout
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic       xd;
        logic       xs1;
        logic       xs2;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rocc_inst_t;

    localparam logic [63:0] ILLEGAL_DATA = '1;

endpackage

// File: rtl/rocc_acc_mac.sv
// Iterative 32x32 unsigned shift-add multiplier, one partial product per cycle.
// done_o is high during the final iteration; product_o then holds the full product.
module rocc_acc_mac #(
    parameter int unsigned MAC_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] multiplicand_i,
    input  logic [31:0] multiplier_i,
    output logic        done_o,
    output logic [63:0] product_o
);
    localparam int unsigned CNT_W = $clog2(MAC_CYCLES);

    logic             running;
    logic [63:0]      mcand;
    logic [31:0]      mplier;
    logic [63:0]      partial;
    logic [CNT_W-1:0] count;

    // Final-iteration sum is exposed combinationally so the accumulator can
    // absorb it on the same edge that retires the last iteration.
    assign product_o = partial + (mplier[0] ? mcand : '0);
    assign done_o    = running && (count == CNT_W'(MAC_CYCLES - 1));

    // Load operands on start, then shift-add once per cycle until done
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            running <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            partial <= '0;
            count   <= '0;
        end else if (start_i) begin
            running <= 1'b1;
            mcand   <= {32'd0, multiplicand_i};
            mplier  <= multiplier_i;
            partial <= '0;
            count   <= '0;
        end else if (running) begin
            partial <= product_o;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            count   <= count + CNT_W'(1);
            if (done_o) running <= 1'b0;
        end
    end

endmodule

// File: rtl/rocc_accumulator.sv
// RoCC accelerator: bank of 64-bit accumulators driven by custom instructions.
// Optional feature macro: ROCC_ACC_MAC_EN (enables funct7=3 MAC and the multiplier).
module rocc_accumulator
    import rocc_acc_pkg::*;
#(
    parameter int unsigned NUM_ACC    = 4,
    parameter int unsigned MAC_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_inst_i,
    input  logic [63:0] cmd_rs1_i,
    input  logic [63:0] cmd_rs2_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [4:0]  resp_rd_o,
    output logic [63:0] resp_data_o,
    output logic        busy_o,
    output logic        illegal_o
);
    localparam int unsigned IDX_W = $clog2(NUM_ACC);

    rocc_inst_t       inst;
    acc_state_e       state;
    logic [63:0]      acc [NUM_ACC];
    logic [IDX_W-1:0] cmd_idx;
    logic [IDX_W-1:0] idx_q;
    logic             xd_q;
    logic [63:0]      acc_cur;
    logic [63:0]      new_val;
    logic [63:0]      imm_result;
    logic             imm_write;
    logic             imm_illegal;
    logic             is_mac;
    logic             mac_done;
    logic [63:0]      mac_product;
    logic [63:0]      mac_sum;
    logic             unused_bits;

    assign inst        = cmd_inst_i;
    assign cmd_idx     = cmd_rs2_i[IDX_W-1:0];
    assign cmd_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign acc_cur     = acc[cmd_idx];
    assign mac_sum     = acc[idx_q] + mac_product;
    assign unused_bits = ^{inst, cmd_rs1_i, cmd_rs2_i, 32'(MAC_CYCLES)};

`ifdef ROCC_ACC_MAC_EN
    rocc_acc_mac #(
        .MAC_CYCLES(MAC_CYCLES)
    ) u_mac (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (cmd_valid_i && (state == IDLE) && is_mac),
        .multiplicand_i(cmd_rs1_i[31:0]),
        .multiplier_i  (cmd_rs2_i[63:32]),
        .done_o        (mac_done),
        .product_o     (mac_product)
    );
`else
    assign mac_done    = 1'b0;
    assign mac_product = '0;
`endif

    // Decode the single-cycle operations and their response values
    always_comb begin
        imm_result  = ILLEGAL_DATA;
        new_val     = acc_cur;
        imm_write   = 1'b0;
        imm_illegal = 1'b0;
        is_mac      = 1'b0;
        case (inst.funct7)
            ACC_WRITE: begin
                imm_result = acc_cur;
                new_val    = cmd_rs1_i;
                imm_write  = 1'b1;
            end
            ACC_READ: imm_result = acc_cur;
            ACC_ACCUM: begin
                new_val    = acc_cur + cmd_rs1_i;
                imm_result = acc_cur + cmd_rs1_i;
                imm_write  = 1'b1;
            end
`ifdef ROCC_ACC_MAC_EN
            ACC_MAC: is_mac = 1'b1;
`endif
            default: imm_illegal = 1'b1;
        endcase
    end

    // Command FSM, accumulator bank and registered response outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            for (int unsigned i = 0; i < NUM_ACC; i++) acc[i] <= '0;
            idx_q        <= '0;
            xd_q         <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_rd_o    <= '0;
            resp_data_o  <= '0;
            illegal_o    <= 1'b0;
        end else begin
            illegal_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        idx_q     <= cmd_idx;
                        xd_q      <= inst.xd;
                        illegal_o <= imm_illegal;
                        if (imm_write) acc[cmd_idx] <= new_val;
                        if (is_mac) begin
                            state     <= EXEC;
                            resp_rd_o <= inst.rd;
                        end else if (inst.xd) begin
                            state        <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_rd_o    <= inst.rd;
                            resp_data_o  <= imm_result;
                        end
                    end
                end
                EXEC: begin
                    if (mac_done) begin
                        acc[idx_q] <= mac_sum;
                        if (xd_q) begin
                            state        <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_data_o  <= mac_sum;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        state        <= IDLE;
                        resp_valid_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rocc_accumulator.sv
// Directed testbench for rocc_accumulator with a response scoreboard.
// Expectations adapt to whether ROCC_ACC_MAC_EN is defined.
module tb_rocc_accumulator;

`ifdef ROCC_ACC_MAC_EN
    localparam bit MAC_EN = 1'b1;
`else
    localparam bit MAC_EN = 1'b0;
`endif

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [31:0] cmd_inst_i;
    logic [63:0] cmd_rs1_i;
    logic [63:0] cmd_rs2_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [4:0]  resp_rd_o;
    logic [63:0] resp_data_o;
    logic        busy_o;
    logic        illegal_o;

    int unsigned checks = 0;
    int unsigned errors = 0;
    resp_t       q[$];
    logic [63:0] m_acc [4];

    rocc_accumulator #(
        .NUM_ACC   (4),
        .MAC_CYCLES(32)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_inst_i  (cmd_inst_i),
        .cmd_rs1_i   (cmd_rs1_i),
        .cmd_rs2_i   (cmd_rs2_i),
        .resp_valid_o(resp_valid_o),
        .resp_ready_i(resp_ready_i),
        .resp_rd_o   (resp_rd_o),
        .resp_data_o (resp_data_o),
        .busy_o      (busy_o),
        .illegal_o   (illegal_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one command; returns the expected response data
    function automatic logic [63:0] model_apply(input logic [6:0] f7, input logic [63:0] rs1,
                                                input logic [63:0] rs2);
        int unsigned idx = 32'(rs2[1:0]);
        logic [63:0] r = '1;
        case (f7)
            7'd0: begin r = m_acc[idx]; m_acc[idx] = rs1; end
            7'd1: r = m_acc[idx];
            7'd2: begin m_acc[idx] = m_acc[idx] + rs1; r = m_acc[idx]; end
            7'd3: if (MAC_EN) begin
                m_acc[idx] = m_acc[idx] + 64'(rs1[31:0]) * 64'(rs2[63:32]);
                r = m_acc[idx];
            end
            default: r = '1;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] mk_inst(input logic [6:0] f7, input logic xd, input logic [4:0] rd);
        return {f7, 10'd0, xd, 2'b00, rd, 7'b0001011};
    endfunction

    task automatic send(input string tag, input logic [6:0] f7, input logic xd, input logic [4:0] rd,
                        input logic [63:0] rs1, input logic [63:0] rs2);
        int unsigned n = 0;
        logic [63:0] r;
        cmd_inst_i  = mk_inst(f7, xd, rd);
        cmd_rs1_i   = rs1;
        cmd_rs2_i   = rs2;
        cmd_valid_i = 1'b1;
        while (cmd_ready_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 64'(cmd_ready_o), 64'd1);
        r = model_apply(f7, rs1, rs2);
        if (xd) q.push_back('{rd, r});
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic expect_resp(input string tag, output int unsigned wait_n, output int unsigned low_n);
        resp_t e;
        wait_n = 0;
        low_n  = 0;
        while (resp_valid_o !== 1'b1 && wait_n < 64) begin
            if (cmd_ready_o === 1'b0) low_n++;
            tick();
            wait_n++;
        end
        check({tag, "_valid"}, 64'(resp_valid_o), 64'd1);
        check({tag, "_busy"}, 64'({cmd_ready_o, busy_o}), 64'b01);
        if (q.size() > 0) begin
            e = q.pop_front();
            check({tag, "_rd"}, 64'(resp_rd_o), 64'(e.rd));
            check({tag, "_data"}, resp_data_o, e.data);
        end
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
        check({tag, "_release"}, 64'({resp_valid_o, cmd_ready_o}), 64'b01);
    endtask

    initial begin
        int unsigned wn, ln;
        bit stable;

        rst_i        = 1'b1;
        cmd_valid_i  = 1'b0;
        cmd_inst_i   = '0;
        cmd_rs1_i    = '0;
        cmd_rs2_i    = '0;
        resp_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) m_acc[i] = '0;
        tick(); tick(); tick();
        rst_i = 1'b0;
        tick();

        // Reset state
        check("rst_ready", 64'(cmd_ready_o), 64'd1);
        check("rst_valid", 64'(resp_valid_o), 64'd0);
        check("rst_rd", 64'(resp_rd_o), 64'd0);
        check("rst_data", resp_data_o, 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_illegal", 64'(illegal_o), 64'd0);

        // WRITE returns old value one cycle after accept; READ sees new value
        send("wr", 7'd0, 1'b1, 5'd5, 64'h1234, 64'd2);
        check("wr_illegal", 64'(illegal_o), 64'd0);
        expect_resp("wr", wn, ln);
        check("wr_latency", 64'(wn), 64'd0);
        send("rd2", 7'd1, 1'b1, 5'd6, 64'd0, 64'hABCD_0000_0000_0006);
        expect_resp("rd2", wn, ln);

        // ACCUM wraps modulo 2^64
        send("acc1", 7'd2, 1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        expect_resp("acc1", wn, ln);
        send("acc2", 7'd2, 1'b1, 5'd8, 64'd2, 64'd1);
        expect_resp("acc2", wn, ln);

        // MAC: 10 + 7*6 = 52 after 32 EXEC cycles (or illegal when disabled)
        send("w10", 7'd0, 1'b0, 5'd0, 64'd10, 64'd0);
        send("mac", 7'd3, 1'b1, 5'd10, 64'hDEAD_0000_0000_0007, {32'd6, 32'd0});
        check("mac_illegal", 64'(illegal_o), MAC_EN ? 64'd0 : 64'd1);
        expect_resp("mac", wn, ln);
        check("mac_latency", 64'(wn), MAC_EN ? 64'd32 : 64'd0);
        check("mac_ready_low", 64'(ln), MAC_EN ? 64'd32 : 64'd0);
        send("rd0", 7'd1, 1'b1, 5'd11, 64'd0, 64'd0);
        expect_resp("rd0", wn, ln);

        // Backpressure: response held stable, pending command accepted after release
        send("bp", 7'd1, 1'b1, 5'd9, 64'd0, 64'd1);
        cmd_inst_i  = mk_inst(7'd0, 1'b0, 5'd0);
        cmd_rs1_i   = 64'h77;
        cmd_rs2_i   = 64'd3;
        cmd_valid_i = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid_o !== 1'b1 || cmd_ready_o !== 1'b0 || q.size() == 0) stable = 1'b0;
            else if (resp_rd_o !== q[0].rd || resp_data_o !== q[0].data) stable = 1'b0;
            tick();
        end
        check("bp_stable", 64'(stable), 64'd1);
        expect_resp("bp", wn, ln);
        void'(model_apply(7'd0, 64'h77, 64'd3));
        tick();
        cmd_valid_i = 1'b0;
        send("rd3", 7'd1, 1'b1, 5'd12, 64'd0, 64'd3);
        expect_resp("rd3", wn, ln);

        // Illegal funct7 with xd=0: single pulse, no response, no state change
        send("ill", 7'd9, 1'b0, 5'd13, 64'h55, 64'd1);
        check("ill_pulse", 64'(illegal_o), 64'd1);
        check("ill_noresp", 64'(resp_valid_o), 64'd0);
        tick();
        check("ill_pulse_end", 64'({illegal_o, resp_valid_o}), 64'd0);
        send("rd1", 7'd1, 1'b1, 5'd14, 64'd0, 64'd1);
        expect_resp("rd1", wn, ln);

        // Four back-to-back WRITEs with xd=0
        for (int i = 0; i < 4; i++) begin
            cmd_inst_i  = mk_inst(7'd0, 1'b0, 5'd0);
            cmd_rs1_i   = 64'(100 + i);
            cmd_rs2_i   = 64'(i);
            cmd_valid_i = 1'b1;
            check($sformatf("b2b_ready%0d", i), 64'(cmd_ready_o), 64'd1);
            void'(model_apply(7'd0, 64'(100 + i), 64'(i)));
            tick();
        end
        cmd_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send($sformatf("b2b_rd%0d", i), 7'd1, 1'b1, 5'(16 + i), 64'd0, 64'(i));
            expect_resp($sformatf("b2b_rd%0d", i), wn, ln);
        end

        // Reset in cycle T+15 of a MAC drops everything
        send("mac_rst", 7'd3, 1'b1, 5'd20, 64'd3, {32'd5, 32'd0});
        for (int i = 0; i < 14; i++) tick();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        q.delete();
        for (int i = 0; i < 4; i++) m_acc[i] = '0;
        tick();
        check("abort_state", 64'({resp_valid_o, busy_o, cmd_ready_o}), 64'b001);
        send("abort_rd0", 7'd1, 1'b1, 5'd21, 64'd0, 64'd0);
        expect_resp("abort_rd0", wn, ln);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
